// File: rtl/sa_bram_read_arbiter.sv
// sa_bram_read_arbiter: round-robin, burst-locked sharing of one BRAM read port between act and wgt tilers
module sa_bram_read_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 2,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  act_req,
  input  logic [ADDR_WIDTH-1:0] act_addr,
  output logic                  act_gnt,
  output logic                  act_rvalid,
  output logic [DATA_WIDTH-1:0] act_rdata,
  input  logic                  wgt_req,
  input  logic [ADDR_WIDTH-1:0] wgt_addr,
  output logic                  wgt_gnt,
  output logic                  wgt_rvalid,
  output logic [DATA_WIDTH-1:0] wgt_rdata,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic                  busy
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST_MAX);
  typedef enum logic [1:0] {NONE = 2'd0, ACT = 2'd1, WGT = 2'd2} owner_t;
  owner_t owner_q, owner_d, last_q, last_d, gnt, other;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] tag_v_q, tag_v_d, tag_id_q, tag_id_d;
  logic o_req, x_req;
  always_comb begin
    other = owner_q == ACT ? WGT : ACT;
    o_req = owner_q == ACT ? act_req : wgt_req;
    x_req = owner_q == ACT ? wgt_req : act_req;
    gnt = NONE;
    if (hold) gnt = NONE;
    else if (owner_q == NONE) gnt = (act_req && wgt_req) ? (last_q == ACT ? WGT : ACT) : act_req ? ACT : wgt_req ? WGT : NONE;
    else gnt = (o_req && (cnt_q < CMAX || !x_req)) ? owner_q : x_req ? other : NONE;
    owner_d = owner_q;
    cnt_d = cnt_q;
    last_d = last_q;
    if (!hold) begin
      if (gnt == NONE) begin
        owner_d = NONE;
        cnt_d = '0;
        last_d = owner_q == NONE ? last_q : owner_q;
      end else if (gnt == owner_q) begin
        cnt_d = cnt_q == CMAX ? cnt_q : cnt_q + CW'(1);
      end else begin
        owner_d = gnt;
        cnt_d = CW'(1);
        last_d = gnt;
      end
    end
  end
  // Outputs are forced low while reset is asserted, including the combinational grants.
  assign act_gnt    = rst && gnt == ACT;
  assign wgt_gnt    = rst && gnt == WGT;
  assign bram_en    = act_gnt | wgt_gnt;
  assign bram_addr  = act_gnt ? act_addr : wgt_gnt ? wgt_addr : '0;
  assign tag_v_d    = RD_LATENCY'({tag_v_q, bram_en});
  assign tag_id_d   = RD_LATENCY'({tag_id_q, wgt_gnt});
  assign act_rvalid = tag_v_q[RD_LATENCY-1] & ~tag_id_q[RD_LATENCY-1];
  assign wgt_rvalid = tag_v_q[RD_LATENCY-1] & tag_id_q[RD_LATENCY-1];
  assign act_rdata  = act_rvalid ? bram_dout : '0;
  assign wgt_rdata  = wgt_rvalid ? bram_dout : '0;
  assign busy       = bram_en | (|tag_v_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q  <= NONE;
      cnt_q    <= '0;
      last_q   <= WGT;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end
endmodule

// File: tb/tb_sa_bram_read_arbiter.sv
// tb_sa_bram_read_arbiter: directed scenario tests for the BRAM read arbiter
module tb_sa_bram_read_arbiter;
  localparam int AW = 12;
  localparam int DW = 64;
  logic clk = 0, rst = 0, hold = 0, act_req = 0, wgt_req = 0;
  logic [AW-1:0] act_addr = '0, wgt_addr = '0;
  logic act_gnt, act_rvalid, wgt_gnt, wgt_rvalid, bram_en, busy;
  logic [DW-1:0] act_rdata, wgt_rdata;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout = '0, d1 = '0;
  int errors = 0, checks = 0;

  sa_bram_read_arbiter dut (
    .clk(clk), .rst(rst), .hold(hold),
    .act_req(act_req), .act_addr(act_addr), .act_gnt(act_gnt), .act_rvalid(act_rvalid), .act_rdata(act_rdata),
    .wgt_req(wgt_req), .wgt_addr(wgt_addr), .wgt_gnt(wgt_gnt), .wgt_rvalid(wgt_rvalid), .wgt_rdata(wgt_rdata),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
    return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
  endfunction

  // Two-cycle BRAM whose contents are a fixed function of the address.
  always @(posedge clk) begin
    d1 <= f(bram_addr);
    bram_dout <= d1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 0; act_req = 0; wgt_req = 0; hold = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0; act_req = 1; wgt_req = 1; hold = 0; act_addr = 12'h123; wgt_addr = 12'h456;
    @(negedge clk);
    checks++;
    if ({act_gnt, wgt_gnt, bram_en, busy, act_rvalid, wgt_rvalid} !== 6'b0 || bram_addr !== '0 || act_rdata !== '0 || wgt_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b%b en=%b busy=%b rv=%b%b addr=%h exp all zero", act_gnt, wgt_gnt, bram_en, busy, act_rvalid, wgt_rvalid, bram_addr);
    end
    tick();
    act_req = 0; wgt_req = 0;
  endtask

  task automatic test_single_act();
    logic ev;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      act_req = c < 6; act_addr = AW'(c);
      @(negedge clk);
      ev = c >= 2 && c < 8;
      checks += 4;
      if (act_gnt !== (c < 6)) begin errors++; $display("FAIL t1_gnt c=%0d got %b exp %b", c, act_gnt, c < 6); end
      if (bram_addr !== (c < 6 ? AW'(c) : AW'(0))) begin errors++; $display("FAIL t1_addr c=%0d got %h", c, bram_addr); end
      if (act_rvalid !== ev || act_rdata !== (ev ? f(AW'(c - 2)) : '0)) begin errors++; $display("FAIL t1_rdata c=%0d got rv=%b d=%h exp rv=%b", c, act_rvalid, act_rdata, ev); end
      if (wgt_rvalid !== 1'b0) begin errors++; $display("FAIL t1_wgt_rvalid c=%0d got %b exp 0", c, wgt_rvalid); end
      tick();
    end
    act_req = 0;
  endtask

  task automatic test_round_robin();
    logic ea;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      act_req = 1; wgt_req = 1; act_addr = AW'(12'h100 + c); wgt_addr = AW'(12'h200 + c);
      @(negedge clk);
      ea = c < 4 || c == 8;
      checks += 3;
      if (act_gnt !== ea || wgt_gnt !== !ea) begin errors++; $display("FAIL t2_gnt c=%0d got a=%b w=%b exp a=%b", c, act_gnt, wgt_gnt, ea); end
      if (bram_en !== 1'b1) begin errors++; $display("FAIL t2_en c=%0d got %b exp 1", c, bram_en); end
      if (bram_addr !== (ea ? act_addr : wgt_addr)) begin errors++; $display("FAIL t2_addr c=%0d got %h", c, bram_addr); end
      tick();
    end
    act_req = 0; wgt_req = 0;
  endtask

  task automatic test_first_grant();
    do_reset();
    act_req = 1; wgt_req = 1;
    @(negedge clk);
    checks++;
    if (act_gnt !== 1'b1 || wgt_gnt !== 1'b0) begin errors++; $display("FAIL t3_first got a=%b w=%b exp a=1 w=0", act_gnt, wgt_gnt); end
    tick();
    act_req = 0; wgt_req = 0;
    @(negedge clk);
    checks++;
    if (bram_en !== 1'b0) begin errors++; $display("FAIL t3_idle got en=%b exp 0", bram_en); end
    tick();
    act_req = 1; wgt_req = 1;
    @(negedge clk);
    checks++;
    if (act_gnt !== 1'b0 || wgt_gnt !== 1'b1) begin errors++; $display("FAIL t3_second got a=%b w=%b exp a=0 w=1", act_gnt, wgt_gnt); end
    tick();
    act_req = 0; wgt_req = 0;
  endtask

  task automatic test_hold();
    logic ea, ew, ev;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      act_req = 1; wgt_req = 1; hold = c >= 2 && c <= 4;
      act_addr = AW'(12'h300 + c); wgt_addr = AW'(12'h380 + c);
      @(negedge clk);
      ea = c < 2 || c == 5 || c == 6;
      ew = c == 7;
      checks++;
      if (act_gnt !== ea || wgt_gnt !== ew) begin errors++; $display("FAIL t4_gnt c=%0d got a=%b w=%b exp a=%b w=%b", c, act_gnt, wgt_gnt, ea, ew); end
      if (c <= 4) begin
        ev = c == 2 || c == 3;
        checks += 2;
        if (act_rvalid !== ev || act_rdata !== (ev ? f(AW'(12'h300 + c - 2)) : '0)) begin errors++; $display("FAIL t4_rdata c=%0d got rv=%b d=%h exp rv=%b", c, act_rvalid, act_rdata, ev); end
        if (busy !== (c != 4)) begin errors++; $display("FAIL t4_busy c=%0d got %b exp %b", c, busy, c != 4); end
      end
      tick();
    end
    act_req = 0; wgt_req = 0; hold = 0;
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      act_req = 1; act_addr = AW'(12'h40 + c);
      @(negedge clk);
      checks++;
      if (act_gnt !== 1'b1) begin errors++; $display("FAIL t5_pre_gnt c=%0d got %b exp 1", c, act_gnt); end
      tick();
    end
    rst = 0; act_req = 1; wgt_req = 1;
    @(negedge clk);
    checks++;
    if ({act_gnt, wgt_gnt, bram_en, busy, act_rvalid, wgt_rvalid} !== 6'b0 || bram_addr !== '0 || act_rdata !== '0) begin
      errors++;
      $display("FAIL t5_in_reset got gnt=%b%b en=%b busy=%b rv=%b%b exp all zero", act_gnt, wgt_gnt, bram_en, busy, act_rvalid, wgt_rvalid);
    end
    tick();
    rst = 1; act_req = 0; wgt_req = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (act_rvalid !== 1'b0 || wgt_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t5_discard c=%0d got rv=%b%b busy=%b exp 0", c, act_rvalid, wgt_rvalid, busy); end
      tick();
    end
    act_req = 1; wgt_req = 1;
    @(negedge clk);
    checks++;
    if (act_gnt !== 1'b1 || wgt_gnt !== 1'b0) begin errors++; $display("FAIL t5_after got a=%b w=%b exp a=1 w=0", act_gnt, wgt_gnt); end
    tick();
    act_req = 0; wgt_req = 0;
  endtask

  task automatic test_handover();
    logic ea;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      act_req = c != 2; wgt_req = 1;
      act_addr = AW'(12'h50 + c); wgt_addr = AW'(12'h60 + c);
      @(negedge clk);
      ea = c < 2 || c == 6;
      checks++;
      if (act_gnt !== ea || wgt_gnt !== !ea) begin errors++; $display("FAIL t6_gnt c=%0d got a=%b w=%b exp a=%b", c, act_gnt, wgt_gnt, ea); end
      if (c == 2) begin
        checks++;
        if (act_rvalid !== 1'b1 || act_rdata !== f(12'h050)) begin errors++; $display("FAIL t6_act_rdata got rv=%b d=%h exp %h", act_rvalid, act_rdata, f(12'h050)); end
      end
      if (c == 4) begin
        checks += 2;
        if (wgt_rvalid !== 1'b1 || wgt_rdata !== f(12'h062)) begin errors++; $display("FAIL t6_wgt_rdata got rv=%b d=%h exp %h", wgt_rvalid, wgt_rdata, f(12'h062)); end
        if (act_rvalid !== 1'b0 || act_rdata !== '0) begin errors++; $display("FAIL t6_act_quiet got rv=%b d=%h exp 0", act_rvalid, act_rdata); end
      end
      tick();
    end
    act_req = 0; wgt_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_act();
    test_round_robin();
    test_first_grant();
    test_hold();
    test_reset_mid_op();
    test_handover();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
